mult_div_controller: RTL and testbench

//  Sequencing controller for the HI/LO multiply/divide resource in the EX stage.

---
 rtl/mult_div_controller.sv | 209 ++++++++++++++++++++
 tb/tb_mult_div_controller.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_controller.sv
// ============================================================================
// Module  : mult_div_controller
// Brief   : EX-stage HI/LO multiply/divide sequencer with pipeline stall.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mult_div_controller #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] hi_lo_out,
    output logic             div_by_zero
);

    localparam int         c_cw         = $clog2(WIDTH);
    localparam logic [c_cw-1:0] c_last  = c_cw'(WIDTH - 1);
    localparam logic [5:0] c_funct_mult  = 6'b011000;
    localparam logic [5:0] c_funct_multu = 6'b011001;
    localparam logic [5:0] c_funct_div   = 6'b011010;
    localparam logic [5:0] c_funct_divu  = 6'b011011;
    localparam logic [5:0] c_funct_mfhi  = 6'b010000;
    localparam logic [5:0] c_funct_mthi  = 6'b010001;
    localparam logic [5:0] c_funct_mflo  = 6'b010010;
    localparam logic [5:0] c_funct_mtlo  = 6'b010011;

    typedef enum logic [1:0] {
        st_idle = 2'd0,
        st_mul  = 2'd1,
        st_div  = 2'd2,
        st_fix  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi_acc;
    logic [WIDTH-1:0] r_lo_acc;
    logic [WIDTH-1:0] r_mag_b;
    logic [c_cw-1:0]  r_count;
    logic             r_neg_res;
    logic             r_neg_rem;
    logic             r_dbz;
    logic             r_op_div;
    logic             r_dbz_pulse;

    logic             w_is_mult;
    logic             w_is_div;
    logic             w_is_signed;
    logic             w_is_hilo;
    logic             w_issue;
    logic             w_mt_ok;
    logic             w_last;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_trial;
    logic             w_qbit;
    logic [WIDTH-1:0] w_div_hi;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    assign w_is_mult   = (funct == c_funct_mult) || (funct == c_funct_multu);
    assign w_is_div    = (funct == c_funct_div)  || (funct == c_funct_divu);
    assign w_is_signed = ~funct[0];
    assign w_is_hilo   = (funct[5:2] == 4'b0100);

    assign busy    = (r_state != st_idle);
    assign w_issue = en & ~flush & ~busy & (w_is_mult | w_is_div);
    assign w_mt_ok = en & ~flush & ~busy;
    assign w_last  = (r_count == c_last);

    assign w_mag_a = (w_is_signed & src_a[WIDTH-1]) ? -src_a : src_a;
    assign w_mag_b = (w_is_signed & src_b[WIDTH-1]) ? -src_b : src_b;

    // Shift-add: accumulate into the upper half, shift the multiplier out of the lower half.
    assign w_mul_sum = {1'b0, r_hi_acc} + (r_lo_acc[0] ? {1'b0, r_mag_b} : '0);

    // Restoring divide: remainder in the upper half, quotient bits shift into the lower half.
    assign w_trial  = {r_hi_acc, r_lo_acc[WIDTH-1]} - {1'b0, r_mag_b};
    assign w_qbit   = ~w_trial[WIDTH];
    assign w_div_hi = w_qbit ? w_trial[WIDTH-1:0] : {r_hi_acc[WIDTH-2:0], r_lo_acc[WIDTH-1]};

    assign w_prod     = {r_hi_acc, r_lo_acc};
    assign w_prod_fix = r_neg_res ? -w_prod : w_prod;
    // A zero divisor leaves the dividend magnitude as remainder, so the remainder
    // sign fix restores the raw dividend and the all-ones quotient is left alone.
    assign w_quo_fix  = (r_neg_res & ~r_dbz) ? -r_lo_acc : r_lo_acc;
    assign w_rem_fix  = r_neg_rem ? -r_hi_acc : r_hi_acc;

    assign stall       = ~reset & en & ~flush & busy & w_is_hilo;
    assign div_by_zero = r_dbz_pulse;

    always_comb begin
        hi_lo_out = '0;
        if (!busy) begin
            if (funct == c_funct_mfhi) begin
                hi_lo_out = r_hi;
            end else if (funct == c_funct_mflo) begin
                hi_lo_out = r_lo;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            st_idle: begin
                if (w_issue) begin
                    w_state_next = w_is_mult ? st_mul : st_div;
                end
            end
            st_mul, st_div: begin
                if (flush) begin
                    w_state_next = st_idle;
                end else if (w_last) begin
                    w_state_next = st_fix;
                end
            end
            default: w_state_next = st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi        <= '0;
            r_lo        <= '0;
            r_hi_acc    <= '0;
            r_lo_acc    <= '0;
            r_mag_b     <= '0;
            r_count     <= '0;
            r_neg_res   <= 1'b0;
            r_neg_rem   <= 1'b0;
            r_dbz       <= 1'b0;
            r_op_div    <= 1'b0;
            r_dbz_pulse <= 1'b0;
        end else begin
            r_dbz_pulse <= 1'b0;
            case (r_state)
                st_idle: begin
                    if (w_issue) begin
                        r_hi_acc  <= '0;
                        r_lo_acc  <= w_mag_a;
                        r_mag_b   <= w_mag_b;
                        r_count   <= '0;
                        r_neg_res <= w_is_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        r_neg_rem <= w_is_signed & w_is_div & src_a[WIDTH-1];
                        r_dbz     <= w_is_div & (src_b == '0);
                        r_op_div  <= w_is_div;
                    end else if (w_mt_ok && funct == c_funct_mthi) begin
                        r_hi <= src_a;
                    end else if (w_mt_ok && funct == c_funct_mtlo) begin
                        r_lo <= src_a;
                    end
                end
                st_mul: begin
                    if (!flush) begin
                        r_hi_acc <= w_mul_sum[WIDTH:1];
                        r_lo_acc <= {w_mul_sum[0], r_lo_acc[WIDTH-1:1]};
                        r_count  <= w_last ? '0 : r_count + 1'b1;
                    end
                end
                st_div: begin
                    if (!flush) begin
                        r_hi_acc <= w_div_hi;
                        r_lo_acc <= {r_lo_acc[WIDTH-2:0], w_qbit};
                        r_count  <= w_last ? '0 : r_count + 1'b1;
                    end
                end
                default: begin
                    if (!flush) begin
                        if (r_op_div) begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quo_fix;
                        end else begin
                            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_fix[WIDTH-1:0];
                        end
                        r_dbz_pulse <= r_op_div & r_dbz;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mult_div_controller.sv
// ============================================================================
// Module  : tb_mult_div_controller
// Brief   : Scoreboard bench for mult_div_controller using directed vectors.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mult_div_controller;

    localparam int W = 32;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic [5:0]   funct;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         flush;
    logic         stall;
    logic         busy;
    logic [W-1:0] hi_lo_out;
    logic         div_by_zero;

    mult_div_controller #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .funct       (funct),
        .src_a       (src_a),
        .src_b       (src_b),
        .flush       (flush),
        .stall       (stall),
        .busy        (busy),
        .hi_lo_out   (hi_lo_out),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] val;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    int           checks = 0;
    int           passes = 0;
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act === req) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every unstalled MFHI/MFLO presents read data to the scoreboard.
    always @(negedge clk) begin
        if (!reset && en && !stall && (funct == F_MFHI || funct == F_MFLO)) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_read: got 0x%08h, expected no read", hi_lo_out);
            end else begin
                mon_e = exp_q.pop_front();
                check(mon_e.name, hi_lo_out, mon_e.val);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_read(input string name, input logic [5:0] f, input logic [W-1:0] v);
        exp_q.push_back('{name: name, val: v});
        en    = 1'b1;
        funct = f;
        tick();
        en    = 1'b0;
    endtask

    task automatic read_both(input string name);
        expect_read({name, "_hi"}, F_MFHI, m_hi);
        expect_read({name, "_lo"}, F_MFLO, m_lo);
    endtask

    task automatic run_op(input string name, input logic [5:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ehi,
                          input logic [W-1:0] elo, input logic edbz);
        int n;
        en    = 1'b1;
        funct = f;
        src_a = a;
        src_b = b;
        tick();
        en = 1'b0;
        #1;
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
            #1;
        end
        check({name, "_busy_cycles"}, n, 33);
        check({name, "_dbz"}, {31'b0, div_by_zero}, {31'b0, edbz});
        tick();
        #1;
        check({name, "_dbz_clear"}, {31'b0, div_by_zero}, 32'd0);
        m_hi = ehi;
        m_lo = elo;
        read_both(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int seen;
        reset = 1'b1;
        en    = 1'b0;
        flush = 1'b0;
        funct = 6'd0;
        src_a = '0;
        src_b = '0;
        repeat (3) tick();
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_dbz", {31'b0, div_by_zero}, 32'd0);
        reset = 1'b0;
        tick();
        m_hi = '0;
        m_lo = '0;
        read_both("reset");

        run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_neg",  F_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("divu",      F_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
        run_op("div_neg",   F_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_ovf",   F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0);
        run_op("divu_zero", F_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1);
        run_op("div_zero",  F_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);

        // MFLO right behind a MULT must stall until the result lands.
        en    = 1'b1;
        funct = F_MULT;
        src_a = 32'hFFFF_FFFD;
        src_b = 32'd7;
        tick();
        funct = F_MFLO;
        exp_q.push_back('{name: "stall_read_lo", val: 32'hFFFF_FFEB});
        #1;
        check("busy_read_zero", hi_lo_out, 32'd0);
        n = 0;
        while (stall && n < 100) begin
            n++;
            tick();
            #1;
        end
        check("stall_cycles", n, 33);
        tick();
        en   = 1'b0;
        m_hi = 32'hFFFF_FFFF;
        m_lo = 32'hFFFF_FFEB;

        en    = 1'b1;
        funct = F_MTHI;
        src_a = 32'h0000_1234;
        tick();
        funct = F_MTLO;
        src_a = 32'hCAFE_F00D;
        tick();
        en   = 1'b0;
        m_hi = 32'h0000_1234;
        m_lo = 32'hCAFE_F00D;
        read_both("mt");

        // Flush beats en: no MT write and no issue.
        en    = 1'b1;
        flush = 1'b1;
        funct = F_MTLO;
        src_a = 32'hDEAD_BEEF;
        tick();
        funct = F_MULTU;
        tick();
        #1;
        check("flush_no_issue", {31'b0, busy}, 32'd0);
        en    = 1'b0;
        flush = 1'b0;
        read_both("flush_wins");

        // Flush a divide-by-zero at iteration 10.
        en    = 1'b1;
        funct = F_DIVU;
        src_a = 32'd5;
        src_b = 32'd0;
        tick();
        en = 1'b0;
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check("flush_busy", {31'b0, busy}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (div_by_zero) seen++;
            tick();
        end
        check("flush_no_dbz", seen, 0);
        read_both("flush_mid");

        // Reset at iteration 20 clears HI/LO and the op.
        en    = 1'b1;
        funct = F_MULTU;
        src_a = 32'd3;
        src_b = 32'd4;
        tick();
        en = 1'b0;
        repeat (20) tick();
        #2;
        reset = 1'b1;
        en    = 1'b1;
        funct = F_MFHI;
        #1;
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_stall", {31'b0, stall}, 32'd0);
        en = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        m_hi = '0;
        m_lo = '0;
        read_both("rst_mid");

        repeat (2) tick();
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
